// File: rtl/idma_req_arb_pkg.sv
// Shared constants and helpers for the iDMA request round-robin arbiter.
package idma_req_arb_pkg;

  localparam int DefaultNumPorts     = 4;
  localparam int DefaultPendingDepth = 8;

  // Width of a port index (port_idx_t); never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/idma_req_rr_arbiter_if.sv
// Frontend and backend handshake bundle of the iDMA request arbiter.
interface idma_req_rr_arbiter_if
  import idma_req_arb_pkg::*;
#(
  parameter int  NumPorts   = DefaultNumPorts,
  parameter type idma_req_t = logic,
  parameter type idma_rsp_t = logic
);

  idma_req_t             req_i [NumPorts];
  logic [NumPorts-1:0]   req_valid_i;
  logic [NumPorts-1:0]   req_ready_o;
  idma_rsp_t             rsp_o [NumPorts];
  logic [NumPorts-1:0]   rsp_valid_o;
  logic [NumPorts-1:0]   rsp_ready_i;

  idma_req_t             idma_req_o;
  logic                  idma_req_valid_o;
  logic                  idma_req_ready_i;
  idma_rsp_t             idma_rsp_i;
  logic                  idma_rsp_valid_i;
  logic                  idma_rsp_ready_o;

  logic                  busy_o;

  modport master (
    output req_i, req_valid_i, rsp_ready_i,
    output idma_req_ready_i, idma_rsp_i, idma_rsp_valid_i,
    input  req_ready_o, rsp_o, rsp_valid_o,
    input  idma_req_o, idma_req_valid_o, idma_rsp_ready_o, busy_o
  );

  modport slave (
    input  req_i, req_valid_i, rsp_ready_i,
    input  idma_req_ready_i, idma_rsp_i, idma_rsp_valid_i,
    output req_ready_o, rsp_o, rsp_valid_o,
    output idma_req_o, idma_req_valid_o, idma_rsp_ready_o, busy_o
  );

endinterface

// File: rtl/idma_req_arb_pending.sv
// In-order FIFO of granted port indices, used to route backend responses.
module idma_req_arb_pending
  import idma_req_arb_pkg::*;
#(
  parameter int Depth = DefaultPendingDepth,
  parameter int Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCnt = Depth[PtrW:0];

  logic [PtrW-1:0]  r_wrPtr;
  logic [PtrW-1:0]  r_rdPtr;
  logic [PtrW:0]    r_count;
  logic [Width-1:0] r_mem [Depth];
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == FullCnt);
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;
  assign o_head   = r_mem[r_rdPtr];

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/idma_req_rr_arbiter.sv
// Round-robin arbiter sharing one iDMA backend between NumPorts frontends.
// Define IDMA_REQ_ARB_CNT_EN to add per-port completion counters (done_cnt_o).
module idma_req_rr_arbiter
  import idma_req_arb_pkg::*;
#(
  parameter int  NumPorts     = DefaultNumPorts,
  parameter int  PendingDepth = DefaultPendingDepth,
  parameter int  CntWidth     = 16,
  parameter type idma_req_t   = logic,
  parameter type idma_rsp_t   = logic
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  idma_req_rr_arbiter_if.slave bus
`ifdef IDMA_REQ_ARB_CNT_EN
  ,
  output logic [CntWidth-1:0]  done_cnt_o [NumPorts]
`endif
);

  localparam int IdxW = idx_width(NumPorts);
  typedef logic [IdxW-1:0] port_idx_t;

  if (NumPorts < 2) begin : g_badPorts
    $error("NumPorts must be at least 2");
  end
  if ((PendingDepth < 2) || ((PendingDepth & (PendingDepth - 1)) != 0)) begin : g_badDepth
    $error("PendingDepth must be a power of two");
  end
  if (CntWidth < 1) begin : g_badCnt
    $error("CntWidth must be at least 1");
  end

  arb_state_e r_lock;
  arb_state_e w_lockNext;
  port_idx_t  r_prio;
  port_idx_t  w_prioNext;
  port_idx_t  r_gnt;
  port_idx_t  w_gntNext;
  port_idx_t  w_rrIdx;
  port_idx_t  w_scanIdx;
  logic       w_rrFound;
  port_idx_t  w_gnt;
  port_idx_t  w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_reqValid;
  logic       w_push;
  logic       w_pop;
  idma_req_t  w_reqSel;
  idma_rsp_t  w_rsp;

  idma_req_arb_pending #(
    .Depth (PendingDepth),
    .Width (IdxW)
  ) i_pending (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  (w_gnt),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // First valid port at or after the rotating priority pointer.
  always_comb begin
    w_rrIdx   = r_prio;
    w_rrFound = 1'b0;
    w_scanIdx = '0;
    for (int k = 0; k < NumPorts; k++) begin
      w_scanIdx = port_idx_t'((int'(r_prio) + k) % NumPorts);
      if (!w_rrFound && bus.req_valid_i[w_scanIdx]) begin
        w_rrIdx   = w_scanIdx;
        w_rrFound = 1'b1;
      end
    end
  end

  // A stalled grant stays locked so the backend sees a stable request.
  assign w_gnt      = (r_lock == ARB_LOCKED) ? r_gnt : w_rrIdx;
  assign w_reqValid = bus.req_valid_i[w_gnt] & ~w_full;
  assign w_push     = w_reqValid & bus.idma_req_ready_i;
  assign w_reqSel   = bus.req_i[w_gnt];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lock <= ARB_FREE;
      r_prio <= '0;
      r_gnt  <= '0;
    end else begin
      r_lock <= w_lockNext;
      r_prio <= w_prioNext;
      r_gnt  <= w_gntNext;
    end
  end

  always_comb begin
    w_lockNext = r_lock;
    w_gntNext  = r_gnt;
    w_prioNext = r_prio;
    case (r_lock)
      ARB_FREE: begin
        if (w_reqValid && !bus.idma_req_ready_i) begin
          w_lockNext = ARB_LOCKED;
          w_gntNext  = w_gnt;
        end
      end
      ARB_LOCKED: begin
        if (w_push) w_lockNext = ARB_FREE;
      end
      default: w_lockNext = ARB_FREE;
    endcase
    if (w_push) begin
      w_lockNext = ARB_FREE;
      w_prioNext = (w_gnt == port_idx_t'(NumPorts - 1)) ? '0 : w_gnt + 1'b1;
    end
  end

  assign w_rsp = bus.idma_rsp_i;

  // Responses are broadcast; only the FIFO head port sees valid.
  always_comb begin
    bus.req_ready_o = '0;
    bus.rsp_valid_o = '0;
    bus.req_ready_o[w_gnt]  = bus.idma_req_ready_i & ~w_full & bus.req_valid_i[w_gnt];
    bus.rsp_valid_o[w_head] = bus.idma_rsp_valid_i & ~w_empty;
    for (int k = 0; k < NumPorts; k++) begin
      bus.rsp_o[k] = w_rsp;
    end
  end

  assign bus.idma_req_o       = w_reqSel;
  assign bus.idma_req_valid_o = w_reqValid;
  assign bus.idma_rsp_ready_o = bus.rsp_ready_i[w_head] & ~w_empty;
  assign bus.busy_o           = ~w_empty;
  assign w_pop                = bus.idma_rsp_valid_i & bus.idma_rsp_ready_o;

`ifdef IDMA_REQ_ARB_CNT_EN
  logic [CntWidth-1:0] r_doneCnt [NumPorts];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumPorts; k++) r_doneCnt[k] <= '0;
    end else if (w_pop && !w_rsp.error) begin
      r_doneCnt[w_head] <= r_doneCnt[w_head] + 1'b1;
    end
  end

  assign done_cnt_o = r_doneCnt;
`endif

  // A backend response with nothing outstanding has no owner.
  assert property (@(posedge clk_i) disable iff (rst_i) !(bus.idma_rsp_valid_i && w_empty));

endmodule

// File: tb/tb_idma_req_rr_arbiter.sv
// Randomized self-checking bench for idma_req_rr_arbiter against a queue-based model.
module tb_idma_req_rr_arbiter;
  import idma_req_arb_pkg::*;

  localparam int NPorts    = 4;
  localparam int PendDepth = 8;
  localparam int CntW      = 16;

  typedef logic [15:0] req_t;
  typedef struct packed {
    logic       error;
    logic [6:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  idma_req_rr_arbiter_if #(
    .NumPorts   (NPorts),
    .idma_req_t (req_t),
    .idma_rsp_t (rsp_t)
  ) bus ();

`ifdef IDMA_REQ_ARB_CNT_EN
  logic [CntW-1:0] doneCnt [NPorts];
`endif

  idma_req_rr_arbiter #(
    .NumPorts     (NPorts),
    .PendingDepth (PendDepth),
    .CntWidth     (CntW),
    .idma_req_t   (req_t),
    .idma_rsp_t   (rsp_t)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus)
`ifdef IDMA_REQ_ARB_CNT_EN
    ,
    .done_cnt_o (doneCnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int prio;
  int lockPort;
  int hsCount;
  int pendQ[$];
  int doneModel[NPorts];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic resetModel();
    prio     = 0;
    lockPort = -1;
    pendQ.delete();
    for (int k = 0; k < NPorts; k++) doneModel[k] = 0;
  endtask

  task automatic applyIdle();
    for (int i = 0; i < NPorts; i++) begin
      bus.req_valid_i[i] = 1'b0;
      bus.req_i[i]       = '0;
      bus.rsp_ready_i[i] = 1'b0;
    end
    bus.idma_req_ready_i = 1'b0;
    bus.idma_rsp_valid_i = 1'b0;
    bus.idma_rsp_i       = '0;
  endtask

  // A stalled port keeps its valid and payload, as a real frontend must.
  task automatic applyStimulus(input int validPct, input int readyPct, input int rspValidPct, input int rspReadyPct);
    logic [7:0] rspBits;
    for (int i = 0; i < NPorts; i++) begin
      if (i == lockPort) begin
        bus.req_valid_i[i] = 1'b1;
      end else begin
        bus.req_valid_i[i] = (int'($urandom_range(99)) < validPct);
        bus.req_i[i]       = req_t'($urandom);
      end
      bus.rsp_ready_i[i] = (int'($urandom_range(99)) < rspReadyPct);
    end
    bus.idma_req_ready_i = (int'($urandom_range(99)) < readyPct);
    bus.idma_rsp_valid_i = (pendQ.size() > 0) && (int'($urandom_range(99)) < rspValidPct);
    rspBits    = 8'($urandom);
    rspBits[7] = (int'($urandom_range(3)) == 0);
    bus.idma_rsp_i = rspBits;
  endtask

  task automatic checkCycle();
    int         gnt;
    int         head;
    int         rk;
    logic       full;
    logic       empty;
    logic       expReqValid;
    logic       expRspReady;
    logic [3:0] expReady;
    logic [3:0] expRspValid;

    full  = (pendQ.size() == PendDepth);
    empty = (pendQ.size() == 0);
    gnt   = -1;
    if (lockPort >= 0) begin
      gnt = lockPort;
    end else begin
      for (int k = 0; k < NPorts; k++) begin
        if (gnt < 0 && bus.req_valid_i[(prio + k) % NPorts]) gnt = (prio + k) % NPorts;
      end
    end
    expReqValid = !full && (gnt >= 0) && bus.req_valid_i[gnt];
    expReady = '0;
    if (expReqValid && bus.idma_req_ready_i) expReady[gnt] = 1'b1;

    head = empty ? -1 : pendQ[0];
    expRspValid = '0;
    expRspReady = 1'b0;
    if (!empty) begin
      expRspValid[head] = bus.idma_rsp_valid_i;
      expRspReady       = bus.rsp_ready_i[head];
    end

    checkOutput("idmaReqValid", bus.idma_req_valid_o, expReqValid);
    checkOutput("reqReady", bus.req_ready_o, expReady);
    if (expReqValid) checkOutput("idmaReqData", bus.idma_req_o, bus.req_i[gnt]);
    checkOutput("rspValid", bus.rsp_valid_o, expRspValid);
    checkOutput("idmaRspReady", bus.idma_rsp_ready_o, expRspReady);
    checkOutput("busy", bus.busy_o, !empty);
    rk = $urandom_range(NPorts - 1);
    checkOutput("rspBroadcast", bus.rsp_o[rk], bus.idma_rsp_i);
`ifdef IDMA_REQ_ARB_CNT_EN
    for (int k = 0; k < NPorts; k++) checkOutput("doneCnt", doneCnt[k], 32'(doneModel[k] % (1 << CntW)));
`endif

    if (bus.idma_req_valid_o && bus.idma_req_ready_i) hsCount++;

    if (!empty && bus.idma_rsp_valid_i && bus.rsp_ready_i[head]) begin
      if (!bus.idma_rsp_i.error) doneModel[head]++;
      void'(pendQ.pop_front());
    end
    if (expReqValid && bus.idma_req_ready_i) begin
      pendQ.push_back(gnt);
      prio     = (gnt + 1) % NPorts;
      lockPort = -1;
    end else if (expReqValid) begin
      lockPort = gnt;
    end
  endtask

  task automatic runCycles(input int n, input int validPct, input int readyPct, input int rspValidPct, input int rspReadyPct);
    for (int c = 0; c < n; c++) begin
      applyStimulus(validPct, readyPct, rspValidPct, rspReadyPct);
      @(negedge clk);
      checkCycle();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Busy"}, bus.busy_o, 1'b0);
    checkOutput({tag, "ReqValid"}, bus.idma_req_valid_o, 1'b0);
    checkOutput({tag, "ReqReady"}, bus.req_ready_o, 4'b0);
    checkOutput({tag, "RspValid"}, bus.rsp_valid_o, 4'b0);
    checkOutput({tag, "RspReady"}, bus.idma_rsp_ready_o, 1'b0);
`ifdef IDMA_REQ_ARB_CNT_EN
    for (int k = 0; k < NPorts; k++) checkOutput({tag, "Cnt"}, doneCnt[k], 32'd0);
`endif
  endtask

  initial begin
    resetModel();
    hsCount = 0;
    rst = 1'b1;
    applyIdle();
    @(negedge clk);
    checkResetState("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Backend never answers: exactly PendDepth grants, then everything stalls.
    hsCount = 0;
    runCycles(12, 100, 100, 0, 0);
    checkOutput("fillHandshakes", hsCount, PendDepth);
    checkOutput("fullBusy", bus.busy_o, 1'b1);
    checkOutput("fullReqReady", bus.req_ready_o, 4'b0);

    // Pop and request together while full: the request waits one cycle.
    hsCount = 0;
    runCycles(1, 100, 100, 100, 100);
    checkOutput("fullPopBlocks", hsCount, 0);
    runCycles(1, 100, 100, 0, 0);
    checkOutput("refillAfterPop", hsCount, 1);

    runCycles(300, 70, 60, 60, 60);
    runCycles(200, 50, 20, 30, 80);
    runCycles(200, 90, 90, 90, 30);

    rst = 1'b1;
    applyIdle();
    resetModel();
    @(negedge clk);
    checkResetState("midReset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    runCycles(200, 60, 70, 60, 70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idma_req_rr_arbiter.md
# idma_req_rr_arbiter

Round-robin arbiter that shares one iDMA backend between `NumPorts` descriptor frontends. It grants one `idma_req_t` stream at a time to the backend and records the granted port index in an in-order pending FIFO. Each backend `idma_rsp_t` is routed back to the port that issued the matching request. It sits between the desc64 frontends and the backend.

## Interface
Parameters:
- `NumPorts`, 4, number of requesting frontends; must be ≥ 2.
- `PendingDepth`, 8, maximum number of transfers in flight at the backend; must be a power of two.
- `CntWidth`, 16, width of the per-port completion counters. Used only with the macro.
- `idma_req_t`, logic, backend request type.
- `idma_rsp_t`, logic, backend response type.

Ports:
- `clk_i` in 1, clock.
- `rst_i` in 1, asynchronous active-high reset.
- `req_i` in `NumPorts` × `idma_req_t`, per-port requests.
- `req_valid_i` in `NumPorts`, request valid.
- `req_ready_o` out `NumPorts`, request ready.
- `rsp_o` out `NumPorts` × `idma_rsp_t`, per-port responses.
- `rsp_valid_o` out `NumPorts`, response valid.
- `rsp_ready_i` in `NumPorts`, response ready.
- `idma_req_o` out `idma_req_t`, request to the backend.
- `idma_req_valid_o` out 1, backend request valid.
- `idma_req_ready_i` in 1, backend request ready.
- `idma_rsp_i` in `idma_rsp_t`, response from the backend.
- `idma_rsp_valid_i` in 1, backend response valid.
- `idma_rsp_ready_o` out 1, backend response ready.
- `busy_o` out 1, asserted when the pending FIFO is non-empty.
- `done_cnt_o` out `NumPorts` × `CntWidth`, completed transfers per port. Present only with the macro.

## Operation
- Arbitration is round-robin. Search starts at `prio_q`, and the first asserted `req_valid_i` wins.
- After a request handshake on port i, `prio_q` becomes (i+1) mod `NumPorts`.
- Lock rule:
  - When `idma_req_valid_o`=1 and `idma_req_ready_i`=0, the grant is latched in `lock_q` and `gnt_q`.
  - The same port stays granted until its handshake completes, even if a higher-priority port raises valid.
  - `idma_req_o` is therefore stable while it is stalled.
- `idma_req_o` = `req_i[gnt]`.
- `req_ready_o[gnt]` = `idma_req_ready_i` AND NOT full. All other ready bits are 0.
- When the FIFO is full, `idma_req_valid_o`=0 and every `req_ready_o` is 0. This holds even if a pop occurs in the same cycle.
- On each request handshake, the granted index is pushed into the pending FIFO.
- Response routing uses the FIFO head index h:
  - `rsp_o[k]` = `idma_rsp_i` for every k.
  - `rsp_valid_o[h]` = `idma_rsp_valid_i` AND NOT empty.
  - `idma_rsp_ready_o` = `rsp_ready_i[h]` AND NOT empty.
- On each response handshake the FIFO pops.
- A backend response while the FIFO is empty is a protocol violation: it is not acknowledged, and an assertion fires.
- A push and a pop in the same cycle keep the occupancy unchanged.
- The occupancy counter is `$clog2(PendingDepth)+1` bits wide. Read and write pointers wrap modulo `PendingDepth`.
- Reset asserted mid-operation:
  - FIFO, `prio_q`, `lock_q` and counters clear immediately.
  - In-flight backend responses are lost; the integrator must reset the backend together with this block.

## Timing
- Request path is combinational: 0-cycle latency from `req_valid_i` to `idma_req_valid_o`.
- Response path is combinational: 0-cycle latency from `idma_rsp_valid_i` to `rsp_valid_o`.
- A FIFO push becomes visible at the head on the next cycle. A response can never be routed to a request issued in the same cycle.
- Reset values:
  - Internal state: `prio_q`=0, `lock_q`=0, `gnt_q`=0, FIFO empty.
  - Outputs: `busy_o`=0, all `req_ready_o`=0 while no request is valid, `idma_req_valid_o`=0, `rsp_valid_o`=0, `idma_rsp_ready_o`=0, `done_cnt_o`=0.
- Throughput: one request and one response per cycle.

## Configuration
- `IDMA_REQ_ARB_CNT_EN` defined:
  - The `done_cnt_o` port is present.
  - `done_cnt_o[h]` increments on each response handshake with `idma_rsp_i.error` = 0.
  - Counters wrap at 2^`CntWidth`.
- `IDMA_REQ_ARB_CNT_EN` undefined: the port and counters are absent, with zero area.

## Structure
- Package `idma_req_arb_pkg` holds:
  - the `port_idx_t` width helper;
  - the default `NumPorts` and `PendingDepth` constants.
- Sub-module `idma_req_arb_pending`:
  - in-order index FIFO with push/pop and full/empty flags;
  - asynchronous active-high reset.

## Test plan
- Two ports, port 0 and port 1, valid every cycle with the backend always ready → grants alternate 0,1,0,1; responses return to ports 0,1,0,1 in order.
- Port 2 valid, backend ready held low for 5 cycles, port 0 raises valid at cycle 2 → `idma_req_o` stays equal to `req_i[2]`; port 0 is granted in the cycle after port 2's handshake.
- `PendingDepth`=8, backend never responds, all ports valid → exactly 8 handshakes; then `req_ready_o`=0 and `busy_o`=1.
- FIFO full, with one response and one new request in the same cycle → the request is blocked that cycle; occupancy goes 8→7, then the next request brings it back to 8.
- Port 1's response presented with `rsp_ready_i[1]`=0 for 3 cycles → `idma_rsp_ready_o`=0 for those cycles; no other port sees `rsp_valid_o`.
- With `IDMA_REQ_ARB_CNT_EN`, 3 transfers on port 3 (one with error), then `rst_i` pulsed → `done_cnt_o[3]`=2 before reset and 0 after.
